// File: rtl/bcd_serial_addsub_disp.sv
// Multi-digit BCD adder/subtractor that resolves one decimal digit per clock
// and drives one active-low 7-segment display per result digit.
module bcd_serial_addsub_disp #(
    parameter int DIGITS        = 2,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  ci,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [1:0]            fsm_state
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is sampled only in IDLE; busy is high for exactly DIGITS
    // cycles while digits are processed; done is a one-cycle pulse marking the
    // cycle in which sum/cout/err have just been loaded. start during RUN/DONE
    // is dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  a_r, b_r, work;
    logic          sub_r, c_r, bad_r;
    logic [IW-1:0] idx;

    logic [3:0]    b_adj, dig;
    logic [4:0]    t;
    logic          c_next, last;
    logic [W+3:0]  wide;
    logic [W-1:0]  work_next;

    function automatic logic any_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Operands shift right each RUN cycle, so the active digit is always at [3:0].
    always_comb begin
        b_adj     = sub_r ? (4'd9 - b_r[3:0]) : b_r[3:0];
        t         = {1'b0, a_r[3:0]} + {1'b0, b_adj} + {4'b0000, c_r};
        if (t > 5'd9) begin
            dig    = 4'(t - 5'd10);
            c_next = 1'b1;
        end else begin
            dig    = t[3:0];
            c_next = 1'b0;
        end
        wide      = {dig, work};
        work_next = wide[W+3:4];
        last      = (idx == IW'(DIGITS - 1));
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_r   <= '0;
            b_r   <= '0;
            work  <= '0;
            sub_r <= 1'b0;
            c_r   <= 1'b0;
            bad_r <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        sub_r <= sub;
                        c_r   <= sub ? ~ci : ci;
                        bad_r <= any_bad(A) | any_bad(B);
                        idx   <= '0;
                        work  <= '0;
                    end
                end
                RUN: begin
                    a_r  <= a_r >> 4;
                    b_r  <= b_r >> 4;
                    c_r  <= c_next;
                    work <= work_next;
                    idx  <= idx + IW'(1);
                    // Outputs update only here, so no partial result is ever visible.
                    if (last) begin
                        if (bad_r) begin
                            sum  <= '0;
                            cout <= 1'b0;
                            err  <= 1'b1;
                        end else begin
                            sum  <= work_next;
                            cout <= sub_r ? ~c_next : c_next;
                            err  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan from the most significant digit; a digit is leading-zero while all above are zero.
    always_comb begin
        logic       hi_zero;
        logic [3:0] d;
        HEX     = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d       = sum[4*i +: 4];
            hi_zero = hi_zero & (d == 4'd0);
            if (BLANK_LEADING && (i > 0) && hi_zero) HEX[7*i +: 7] = 7'h7F;
            else                                     HEX[7*i +: 7] = seg(d);
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub_disp.sv
// Directed bench for bcd_serial_addsub_disp: a 2-digit plain instance and a
// 4-digit instance with leading-zero blanking.
module tb_bcd_serial_addsub_disp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start2 = 1'b0, sub2 = 1'b0, ci2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, err2;
    logic [7:0]  sum2;
    logic [13:0] hex2;
    logic [1:0]  st2;

    logic        start4 = 1'b0, sub4 = 1'b0, ci4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, err4;
    logic [15:0] sum4;
    logic [27:0] hex4;
    logic [1:0]  st4;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_q[$];

    bcd_serial_addsub_disp #(.DIGITS(2), .BLANK_LEADING(1'b0)) dut2 (
        .Clock(clk), .Reset(rst), .start(start2), .sub(sub2), .ci(ci2),
        .A(a2), .B(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .err(err2), .HEX(hex2), .fsm_state(st2)
    );

    bcd_serial_addsub_disp #(.DIGITS(4), .BLANK_LEADING(1'b1)) dut4 (
        .Clock(clk), .Reset(rst), .start(start4), .sub(sub4), .ci(ci4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .err(err4), .HEX(hex4), .fsm_state(st4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one op on the selected instance and return at the negedge where done is seen.
    task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, output int lat);
        @(negedge clk);
        if (sel) begin a4 = a; b4 = b; sub4 = s; ci4 = c; start4 = 1'b1; end
        else begin a2 = a[7:0]; b2 = b[7:0]; sub2 = s; ci2 = c; start2 = 1'b1; end
        next_cycle();
        start2 = 1'b0;
        start4 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            next_cycle();
            lat++;
            if ((sel ? done4 : done2) === 1'b1) break;
        end
    endtask

    task automatic op_check(input string tag, input bit sel, input logic [15:0] a,
                            input logic [15:0] b, input logic s, input logic c,
                            input logic [15:0] e_sum, input logic e_cout, input logic e_err);
        int lat;
        logic [31:0] e;
        exp_q.push_back({16'h0, e_sum});
        run_op(sel, a, b, s, c, lat);
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, sel ? 4 : 2);
        check({tag, "_sum"}, sel ? {16'h0, sum4} : {24'h0, sum2}, e);
        check({tag, "_cout"}, sel ? cout4 : cout2, e_cout);
        check({tag, "_err"}, sel ? err4 : err2, e_err);
        next_cycle();
        check({tag, "_pulse"}, sel ? done4 : done2, 1'b0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy2", busy2, 1'b0);
        check("rst_done2", done2, 1'b0);
        check("rst_sum2", sum2, 8'h00);
        check("rst_cout2", cout2, 1'b0);
        check("rst_err2", err2, 1'b0);
        check("rst_hex2", hex2, {7'h40, 7'h40});
        check("rst_hex4", hex4, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        rst = 1'b0;
        next_cycle();

        op_check("add47_38", 0, 16'h47, 16'h38, 1'b0, 1'b0, 16'h85, 1'b0, 1'b0);
        check("hex_85", hex2, {7'h00, 7'h12});
        op_check("add99_99", 0, 16'h99, 16'h99, 1'b0, 1'b1, 16'h99, 1'b1, 1'b0);
        op_check("add00_00", 0, 16'h00, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0);
        op_check("sub03_05", 0, 16'h03, 16'h05, 1'b1, 1'b0, 16'h98, 1'b1, 1'b0);
        op_check("sub50_25", 0, 16'h50, 16'h25, 1'b1, 1'b1, 16'h24, 1'b0, 1'b0);
        op_check("err1A_01", 0, 16'h1A, 16'h01, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1);
        op_check("clr10_05", 0, 16'h10, 16'h05, 1'b0, 1'b0, 16'h15, 1'b0, 1'b0);

        // start pulsed while RUN must neither disturb nor queue an operation
        @(negedge clk);
        a2 = 8'h12; b2 = 8'h34; sub2 = 1'b0; ci2 = 1'b0; start2 = 1'b1;
        next_cycle();
        a2 = 8'h99; b2 = 8'h99; start2 = 1'b1;
        check("run_busy", busy2, 1'b1);
        next_cycle();
        start2 = 1'b0;
        check("run_nodone", done2, 1'b0);
        next_cycle();
        check("ign_done", done2, 1'b1);
        check("ign_sum", sum2, 8'h46);
        seen = 0;
        repeat (6) begin
            next_cycle();
            if (done2 === 1'b1) seen++;
        end
        check("ign_noqueue", seen, 0);

        // reset one edge into RUN aborts the operation
        @(negedge clk);
        a2 = 8'h47; b2 = 8'h38; start2 = 1'b1;
        next_cycle();
        start2 = 1'b0;
        rst = 1'b1;
        next_cycle();
        check("abort_busy", busy2, 1'b0);
        check("abort_done", done2, 1'b0);
        check("abort_sum", sum2, 8'h00);
        check("abort_hex0", hex2[6:0], 7'h40);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            next_cycle();
            if (done2 === 1'b1) seen++;
        end
        check("abort_nodone", seen, 0);

        op_check("d4_0005", 1, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
        check("hex_0005", hex4, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        op_check("d4_0105", 1, 16'h0100, 16'h0005, 1'b0, 1'b0, 16'h0105, 1'b0, 1'b0);
        check("hex_0105", hex4, {7'h7F, 7'h79, 7'h40, 7'h12});
        op_check("d4_0000", 1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("hex_0000", hex4, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        op_check("d4_sub", 1, 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0999, 1'b0, 1'b0);
        check("hex_0999", hex4, {7'h7F, 7'h10, 7'h10, 7'h10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
